// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - shared interrupt definitions: nesting depth, sequencer states, ISR vectors
package irq_pkg;

   localparam int IRQ_DEPTH = 2;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_JUMP    = 2'd1,
      ST_RESTORE = 2'd2
   } seq_state_e;

   localparam logic [15:0] VEC_IRQ0 = 16'h0020;
   localparam logic [15:0] VEC_IRQ1 = 16'h0040;
   localparam logic [15:0] VEC_IRQ2 = 16'h0060;
   localparam logic [15:0] VEC_IRQ3 = 16'h0080;
   localparam logic [15:0] VEC_IRQ4 = 16'h00A0;

   // ISR vectors sit on a 32-byte grid starting at VEC_IRQ0
   function automatic logic [15:0] vec_of(input logic [2:0] n);
      return VEC_IRQ0 + (16'(n) << 5);
   endfunction

endpackage

// File: rtl/irq_frame_stack.sv
// rtl/irq_frame_stack.sv - LIFO of saved {pc, flags} frames, registered storage, combinational top
module irq_frame_stack
   import irq_pkg::*;
#(
   parameter int DEPTH = IRQ_DEPTH,
   parameter int W     = 20
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] wr_data,
   output logic [W-1:0] top,
   output logic [1:0]   count,
   output logic         full,
   output logic         empty
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0] mem [DEPTH];
   logic [1:0]   cnt_m1;

   assign full   = (count == 2'(DEPTH));
   assign empty  = (count == 2'd0);
   assign cnt_m1 = count - 2'd1;
   assign top    = mem[cnt_m1[IDX_W-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= 2'd0;
      end else if (push && !full) begin
         count <= count + 2'd1;
      end else if (pop && !empty) begin
         count <= count - 2'd1;
      end
   end

   // storage is deliberately left out of reset; contents are only read below count
   always_ff @(posedge clk) begin
      if (push && !full) begin
         mem[count[IDX_W-1:0]] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (!(push && full));
         assert (!(pop && empty));
      end
   end

endmodule

// File: rtl/irq_seq.sv
// rtl/irq_seq.sv - interrupt entry/exit sequencer between the core and irq_ctrl
module irq_seq
   import irq_pkg::*;
#(
   parameter int DEPTH = IRQ_DEPTH,
   parameter int PC_W  = 16,
   parameter int FLG_W = 4
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_insn_done,
   input  logic             i_gie,
   input  logic             i_reti,
   input  logic [PC_W-1:0]  i_pc_next,
   input  logic [FLG_W-1:0] i_flags,
   input  logic             i_irq_take,
   input  logic [15:0]      i_irq_vector,
   output logic             o_int_en,
   output logic             o_irq_ret,
   output logic             o_in_irq,
   output logic             o_pc_load,
   output logic [PC_W-1:0]  o_pc_val,
   output logic             o_flg_load,
   output logic [FLG_W-1:0] o_flg_val,
   output logic             o_stall,
   output logic [1:0]       o_depth,
   output logic             o_err
);

   localparam int FRM_W = PC_W + FLG_W;

   seq_state_e       state, state_nx;
   logic [PC_W-1:0]  vec_r;
   logic [FRM_W-1:0] ret_r;
   logic             err_r;

   logic             bnd, ret_ok, take_ok;
   logic             entry, leave, chain, err_set;
   logic             push, pop, full, empty;
   logic [FRM_W-1:0] top;
   logic [1:0]       count;

   irq_frame_stack #(
      .DEPTH (DEPTH),
      .W     (FRM_W)
   ) u_stack (
      .clk     (i_clk),
      .rst     (i_rst),
      .push    (push),
      .pop     (pop),
      .wr_data ({i_pc_next, i_flags}),
      .top     (top),
      .count   (count),
      .full    (full),
      .empty   (empty)
   );

   // int_en and irq_ret must not depend on i_irq_take: irq_ctrl forms take from int_en
   assign bnd       = (state == ST_IDLE) && i_insn_done;
   assign ret_ok    = i_reti && !empty;
   assign o_int_en  = bnd && i_gie && (!full || ret_ok);
   assign o_irq_ret = bnd && ret_ok;

   assign take_ok = i_irq_take && o_int_en;
   assign entry   = take_ok && !ret_ok;
   assign chain   = take_ok && ret_ok;
   assign leave   = o_irq_ret && !take_ok;
   assign err_set = (bnd && i_reti && empty) || (i_irq_take && !o_int_en);

   assign o_in_irq = !empty;
   assign o_depth  = count;
   assign o_stall  = (state != ST_IDLE);
   assign o_err    = err_r;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state <= ST_IDLE;
         vec_r <= '0;
         ret_r <= '0;
         err_r <= 1'b0;
      end else begin
         state <= state_nx;
         if (entry || chain) begin
            vec_r <= i_irq_vector[PC_W-1:0];
         end
         if (leave) begin
            ret_r <= top;
         end
         if (err_set) begin
            err_r <= 1'b1;
         end
      end
   end

   always_comb begin
      state_nx   = state;
      push       = 1'b0;
      pop        = 1'b0;
      o_pc_load  = 1'b0;
      o_pc_val   = '0;
      o_flg_load = 1'b0;
      o_flg_val  = '0;
      case (state)
         ST_IDLE: begin
            if (entry) begin
               push     = 1'b1;
               state_nx = ST_JUMP;
            end else if (leave) begin
               pop      = 1'b1;
               state_nx = ST_RESTORE;
            end else if (chain) begin
               state_nx = ST_JUMP;
            end
         end
         ST_JUMP: begin
            o_pc_load = 1'b1;
            o_pc_val  = vec_r;
            state_nx  = ST_IDLE;
         end
         ST_RESTORE: begin
            o_pc_load  = 1'b1;
            o_pc_val   = ret_r[FRM_W-1:FLG_W];
            o_flg_load = 1'b1;
            o_flg_val  = ret_r[FLG_W-1:0];
            state_nx   = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         assert (!(bnd && i_irq_take && full && !i_reti));
      end
   end

endmodule

// File: tb/tb_irq_seq.sv
// tb/tb_irq_seq.sv - directed self-checking bench for irq_seq
module tb_irq_seq;

   logic        clk = 1'b0;
   logic        rst, insn_done, gie, reti, irq_take;
   logic [15:0] pc_next, irq_vector;
   logic [3:0]  flags;
   logic        int_en, irq_ret, in_irq, pc_load, flg_load, stall, err;
   logic [15:0] pc_val;
   logic [3:0]  flg_val;
   logic [1:0]  depth;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   irq_seq dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_insn_done  (insn_done),
      .i_gie        (gie),
      .i_reti       (reti),
      .i_pc_next    (pc_next),
      .i_flags      (flags),
      .i_irq_take   (irq_take),
      .i_irq_vector (irq_vector),
      .o_int_en     (int_en),
      .o_irq_ret    (irq_ret),
      .o_in_irq     (in_irq),
      .o_pc_load    (pc_load),
      .o_pc_val     (pc_val),
      .o_flg_load   (flg_load),
      .o_flg_val    (flg_val),
      .o_stall      (stall),
      .o_depth      (depth),
      .o_err        (err)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      insn_done  = 1'b0;
      gie        = 1'b0;
      reti       = 1'b0;
      irq_take   = 1'b0;
      pc_next    = 16'h0;
      flags      = 4'h0;
      irq_vector = 16'h0;
   endtask

   task automatic do_reset();
      idle_in();
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
   endtask

   // boundary with take; leaves the DUT in JUMP with inputs idle
   task automatic enter(input logic [15:0] vec, input logic [15:0] pc, input logic [3:0] flg);
      idle_in();
      insn_done = 1'b1; gie = 1'b1; irq_take = 1'b1;
      irq_vector = vec; pc_next = pc; flags = flg;
      step();
      idle_in();
   endtask

   task automatic ret_boundary(input logic g);
      idle_in();
      insn_done = 1'b1; reti = 1'b1; gie = g; pc_next = 16'h0FFF;
      #1;
   endtask

   initial begin
      rst = 1'b1;
      idle_in();
      step(); step();
      rst = 1'b0;
      #1;

      check("rst_depth",  depth,   0);
      check("rst_in_irq", in_irq,  0);
      check("rst_pcload", pc_load, 0);
      check("rst_stall",  stall,   0);
      check("rst_err",    err,     0);
      check("rst_int_en", int_en,  0);

      // entry / exit
      idle_in();
      insn_done = 1'b1; gie = 1'b1; irq_take = 1'b1;
      irq_vector = 16'h0040; pc_next = 16'h1234; flags = 4'hA;
      #1;
      check("ent_int_en", int_en, 1);
      check("ent_noret",  irq_ret, 0);
      step();
      idle_in();
      check("ent_pcload", pc_load, 1);
      check("ent_pcval",  pc_val, 16'h0040);
      check("ent_noflg",  flg_load, 0);
      check("ent_stall",  stall, 1);
      check("ent_depth",  depth, 1);
      check("ent_in_irq", in_irq, 1);
      step();
      check("ent_idle",   stall, 0);
      ret_boundary(1'b1);
      check("ex_irq_ret", irq_ret, 1);
      step();
      idle_in();
      check("ex_pcload",  pc_load, 1);
      check("ex_pcval",   pc_val, 16'h1234);
      check("ex_flgload", flg_load, 1);
      check("ex_flgval",  flg_val, 4'hA);
      check("ex_depth",   depth, 0);
      step();

      // nesting
      enter(16'h0040, 16'h1234, 4'hA);
      step();
      enter(16'h00A0, 16'h0022, 4'h5);
      check("nest_pcval", pc_val, 16'h00A0);
      check("nest_depth", depth, 2);
      step();
      insn_done = 1'b1; gie = 1'b1;
      #1;
      check("nest_full_inten", int_en, 0);
      step();
      ret_boundary(1'b1);
      check("nest_ret1", irq_ret, 1);
      step();
      idle_in();
      check("nest_pc1",  pc_val, 16'h0022);
      check("nest_flg1", flg_val, 4'h5);
      check("nest_d1",   depth, 1);
      step();
      ret_boundary(1'b1);
      step();
      idle_in();
      check("nest_pc2",  pc_val, 16'h1234);
      check("nest_flg2", flg_val, 4'hA);
      check("nest_d0",   depth, 0);
      step();

      // tail-chain
      enter(16'h0040, 16'h1234, 4'hA);
      step();
      ret_boundary(1'b1);
      irq_take = 1'b1; irq_vector = 16'h0080;
      #1;
      check("tc_irq_ret", irq_ret, 1);
      check("tc_int_en",  int_en, 1);
      step();
      idle_in();
      check("tc_pcload",  pc_load, 1);
      check("tc_pcval",   pc_val, 16'h0080);
      check("tc_noflg",   flg_load, 0);
      check("tc_depth",   depth, 1);
      step();
      ret_boundary(1'b0);
      check("tc_gie0_ret",   irq_ret, 1);
      check("tc_gie0_inten", int_en, 0);
      step();
      idle_in();
      check("tc_pcret",  pc_val, 16'h1234);
      check("tc_flgret", flg_val, 4'hA);
      check("tc_d0",     depth, 0);
      check("tc_noerr",  err, 0);
      step();

      // errors
      ret_boundary(1'b1);
      check("e_reti0_noret", irq_ret, 0);
      step();
      idle_in();
      check("e_reti0_nopc",  pc_load, 0);
      check("e_reti0_err",   err, 1);
      check("e_reti0_stall", stall, 0);
      step(); step();
      check("e_err_held",    err, 1);
      do_reset();
      check("e_err_clr",     err, 0);
      insn_done = 1'b1; gie = 1'b0; irq_take = 1'b1; irq_vector = 16'h0060;
      #1;
      check("e_gie0_inten", int_en, 0);
      step();
      idle_in();
      check("e_gie0_nopc",  pc_load, 0);
      check("e_gie0_depth", depth, 0);
      check("e_gie0_err",   err, 1);

      // reset in JUMP
      do_reset();
      enter(16'h0020, 16'h3000, 4'h3);
      check("r_jump_pcload", pc_load, 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      check("r_pcload", pc_load, 0);
      check("r_depth",  depth, 0);
      check("r_stall",  stall, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
